// File: rtl/mrelbp_pkg.sv
// Shared types and per-radius sampling coordinates for the MRELBP ring interpolator.
// Coordinates are Q16.8. Index [r][i] is radius r, off-axis sample k = 2*i+1.
package mrelbp_pkg;

  localparam int NUM_RADII = 4;

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;
  typedef logic [23:0] coord_t;

  // Every radius uses the same pattern: k1=(a,a), k3=(b,a), k5=(b,b), k7=(a,b).
  localparam coord_t COEFF_X [NUM_RADII][4] = '{
    '{24'h000380, 24'h000080, 24'h000080, 24'h000380},
    '{24'h00067C, 24'h000184, 24'h000184, 24'h00067C},
    '{24'h000A3E, 24'h0001C2, 24'h0001C2, 24'h000A3E},
    '{24'h000D8A, 24'h000276, 24'h000276, 24'h000D8A}
  };

  localparam coord_t COEFF_Y [NUM_RADII][4] = '{
    '{24'h000380, 24'h000380, 24'h000080, 24'h000080},
    '{24'h00067C, 24'h00067C, 24'h000184, 24'h000184},
    '{24'h000A3E, 24'h000A3E, 24'h0001C2, 24'h0001C2},
    '{24'h000D8A, 24'h000D8A, 24'h000276, 24'h000276}
  };

endpackage

// File: rtl/bilinear_cal.sv
// Combinational bilinear interpolator. The result is Q16.8: the weighted sum of the four
// pixels, using the coordinate fractions as weights, truncated to 8 fractional bits.
module bilinear_cal #(
  parameter int WIDTH = 8,
  parameter int FIXED = 24
) (
  input  logic [WIDTH-1:0] i_p00,
  input  logic [WIDTH-1:0] i_p01,
  input  logic [WIDTH-1:0] i_p10,
  input  logic [WIDTH-1:0] i_p11,
  input  logic [7:0]       i_x_frac,
  input  logic [7:0]       i_y_frac,
  output logic [FIXED-1:0] o_result
);

  logic [8:0]  wx1, wx0, wy1, wy0;
  logic [17:0] w00, w01, w10, w11;
  logic [31:0] acc;

  // p01 is the x-neighbour, p10 the y-neighbour; weights sum to 256*256.
  assign wx1 = {1'b0, i_x_frac};
  assign wy1 = {1'b0, i_y_frac};
  assign wx0 = 9'd256 - wx1;
  assign wy0 = 9'd256 - wy1;

  assign w00 = 18'(wx0) * 18'(wy0);
  assign w01 = 18'(wx1) * 18'(wy0);
  assign w10 = 18'(wx0) * 18'(wy1);
  assign w11 = 18'(wx1) * 18'(wy1);

  assign acc = 32'(w00) * 32'(i_p00) + 32'(w01) * 32'(i_p01)
             + 32'(w10) * 32'(i_p10) + 32'(w11) * 32'(i_p11);

  assign o_result = FIXED'(acc >> 8);

endmodule

// File: rtl/interp_sched.sv
// Runs the four off-axis samples of one ring through a single shared bilinear_cal,
// one per cycle, and presents them together with the pass-through on-axis samples.
module interp_sched
  import mrelbp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int FIXED = 24,
  parameter int RADII = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [$clog2(RADII)-1:0]   i_radius,
  input  logic [16*WIDTH-1:0]        i_quads,
  input  logic [4*WIDTH-1:0]         i_axis,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [4*WIDTH-1:0]         o_axis,
  output logic [4*FIXED-1:0]         o_interp,
  output logic                       o_busy
);

  localparam int RW = $clog2(RADII);

  state_t                          state_q, state_d;
  logic [1:0]                      kcnt_q, kcnt_d;
  logic [3:0][3:0][WIDTH-1:0]      quads_q, quads_d;
  logic [RW-1:0]                   radius_q, radius_d;
  logic [4*WIDTH-1:0]              axis_q, axis_d;
  logic [3:0][FIXED-1:0]           res_q, res_d;
  logic                            o_valid_q, o_valid_d;
  logic [FIXED-1:0]                bl_result;

  bilinear_cal #(.WIDTH(WIDTH), .FIXED(FIXED)) u_bilinear (
    .i_p00    (quads_q[kcnt_q][0]),
    .i_p01    (quads_q[kcnt_q][1]),
    .i_p10    (quads_q[kcnt_q][2]),
    .i_p11    (quads_q[kcnt_q][3]),
    .i_x_frac (COEFF_X[radius_q][kcnt_q][7:0]),
    .i_y_frac (COEFF_Y[radius_q][kcnt_q][7:0]),
    .o_result (bl_result)
  );

  always_comb begin
    state_d   = state_q;
    kcnt_d    = kcnt_q;
    quads_d   = quads_q;
    radius_d  = radius_q;
    axis_d    = axis_q;
    res_d     = res_q;
    o_valid_d = o_valid_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          quads_d  = i_quads;
          axis_d   = i_axis;
          radius_d = i_radius;
          kcnt_d   = 2'd0;
          state_d  = CALC;
        end
      end
      CALC: begin
        res_d[kcnt_q] = bl_result;
        kcnt_d        = kcnt_q + 2'd1;
        if (kcnt_q == 2'd3) begin
          state_d   = OUT;
          o_valid_d = 1'b1;
        end
      end
      OUT: begin
        if (i_ready) begin
          state_d   = IDLE;
          o_valid_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        o_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      kcnt_q    <= '0;
      quads_q   <= '0;
      radius_q  <= '0;
      axis_q    <= '0;
      res_q     <= '0;
      o_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      kcnt_q    <= kcnt_d;
      quads_q   <= quads_d;
      radius_q  <= radius_d;
      axis_q    <= axis_d;
      res_q     <= res_d;
      o_valid_q <= o_valid_d;
    end
  end

  // Handshake outputs decode registered state only, so no input reaches them combinationally.
  assign o_ready  = (state_q == IDLE);
  assign o_busy   = (state_q != IDLE);
  assign o_valid  = o_valid_q;
  assign o_axis   = axis_q;
  assign o_interp = res_q;

endmodule

// File: tb/tb_interp_sched.sv
// Directed bench for interp_sched: table of rings with hand-computed interpolations,
// plus sequences for backpressure, busy-time input, mid-ring reset and late radius change.
module tb_interp_sched;

  localparam int WIDTH = 8;
  localparam int FIXED = 24;

  logic                 i_clk = 1'b0;
  logic                 i_rst;
  logic                 i_valid;
  logic                 o_ready;
  logic [1:0]           i_radius;
  logic [16*WIDTH-1:0]  i_quads;
  logic [4*WIDTH-1:0]   i_axis;
  logic                 o_valid;
  logic                 i_ready;
  logic [4*WIDTH-1:0]   o_axis;
  logic [4*FIXED-1:0]   o_interp;
  logic                 o_busy;

  interp_sched #(.WIDTH(WIDTH), .FIXED(FIXED), .RADII(4)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_radius (i_radius),
    .i_quads  (i_quads),
    .i_axis   (i_axis),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_axis   (o_axis),
    .o_interp (o_interp),
    .o_busy   (o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string        name;
    logic [127:0] quads;
    logic [31:0]  axis;
    logic [1:0]   radius;
    logic [95:0]  exp_interp;
  } vec_t;

  vec_t vecs [5];
  int   ntests = 0;
  int   nfail  = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  // Wait for o_valid after an accept edge; returns cycles since accept (5 expected).
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!o_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_ring(input vec_t v, input logic [1:0] late_rad);
    int lat;
    i_ready = 1'b1;
    chk({v.name, " ready"}, 128'(o_ready), 128'(1));
    i_quads  = v.quads;
    i_axis   = v.axis;
    i_radius = v.radius;
    i_valid  = 1'b1;
    tick();
    i_valid  = 1'b0;
    i_radius = late_rad;
    i_quads  = '0;
    i_axis   = '0;
    chk({v.name, " busy"}, 128'({o_busy, o_ready}), 128'(2'b10));
    wait_valid(lat);
    chk({v.name, " latency"}, 128'(lat), 128'(5));
    chk({v.name, " interp"}, 128'(o_interp), 128'(v.exp_interp));
    chk({v.name, " axis"}, 128'(o_axis), 128'(v.axis));
    tick();
    chk({v.name, " release"}, 128'({o_valid, o_ready}), 128'(2'b01));
  endtask

  initial begin
    int lat;
    vecs[0] = '{"flat40", {4{32'h40404040}}, {8'h11, 8'h22, 8'h33, 8'h44}, 2'd2,
                {4{24'h004000}}};
    vecs[1] = '{"order", {32'h30303030, 32'h20202020, 32'h10101010, 32'h00000000},
                32'hA1B2C3D4, 2'd2, {24'h003000, 24'h002000, 24'h001000, 24'h000000}};
    vecs[2] = '{"p01r2", {4{32'h00008000}}, 32'h01020304, 2'd2,
                {24'h000782, 24'h00177E, 24'h004982, 24'h00177E}};
    vecs[3] = '{"mixed", {4{32'h281E140A}}, 32'hDEADBEEF, 2'd2,
                {24'h001B94, 24'h0020BC, 24'h00166C, 24'h001144}};
    vecs[4] = '{"p01r0", {4{32'h00008000}}, 32'h55AA55AA, 2'd0, {4{24'h002000}}};

    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    i_radius = '0; i_quads = '0; i_axis = '0;
    tick(); tick();
    chk("reset outputs", 128'({o_valid, o_busy, o_axis, o_interp}), 128'(0));
    i_rst = 1'b0;
    #1;
    chk("ready after reset", 128'({o_ready, o_busy}), 128'(2'b10));

    for (int i = 0; i < 5; i++) run_ring(vecs[i], vecs[i].radius);

    // Backpressure with i_valid held and inputs churning while busy.
    i_ready  = 1'b0;
    i_quads  = vecs[1].quads;
    i_axis   = vecs[1].axis;
    i_radius = 2'd2;
    i_valid  = 1'b1;
    tick();
    wait_valid(lat);
    chk("bp latency", 128'(lat), 128'(5));
    for (int c = 0; c < 10; c++) begin
      i_quads = {$urandom, $urandom, $urandom, $urandom};
      i_axis  = $urandom;
      tick();
      chk("bp hold", 128'({o_valid, o_ready, o_axis, o_interp}),
          128'({2'b10, vecs[1].axis, vecs[1].exp_interp}));
    end
    i_quads = vecs[3].quads;
    i_axis  = vecs[3].axis;
    i_ready = 1'b1;
    tick();
    chk("bp idle", 128'({o_valid, o_ready}), 128'(2'b01));
    tick();
    chk("bp next accept", 128'({o_busy, o_ready}), 128'(2'b10));
    i_valid = 1'b0;
    i_quads = '0;
    wait_valid(lat);
    chk("bp2 latency", 128'(lat), 128'(5));
    chk("bp2 interp", 128'(o_interp), 128'(vecs[3].exp_interp));
    chk("bp2 axis", 128'(o_axis), 128'(vecs[3].axis));
    tick();

    // Reset two samples into a ring.
    i_quads  = vecs[3].quads;
    i_axis   = vecs[3].axis;
    i_radius = 2'd2;
    i_valid  = 1'b1;
    tick();
    i_valid = 1'b0;
    tick(); tick();
    chk("pre-reset busy", 128'(o_busy), 128'(1));
    i_rst = 1'b1;
    #1;
    chk("mid reset", 128'({o_valid, o_busy, o_axis, o_interp}), 128'(0));
    tick();
    i_rst = 1'b0;
    #1;
    chk("post reset ready", 128'(o_ready), 128'(1));
    run_ring(vecs[0], 2'd2);

    // Radius changes right after accept; in-flight ring keeps radius 2.
    run_ring(vecs[2], 2'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
